// File: rtl/mem_burst_reader.sv
// Burst reader: fetches 1..MAX_BURST consecutive image elements along a row or column,
// translating {row, col} to linear addresses and zero-padding out-of-image elements.
module mem_burst_reader #(
  parameter int DATA_W    = 16,
  parameter int COORD_W   = 16,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int MEM_LAT   = 1,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        START,
  input  logic [COORD_W-1:0]          ROW,
  input  logic [COORD_W-1:0]          COL,
  input  logic                        VERTICAL,
  input  logic [LEN_W-1:0]            LEN,
  input  logic                        SIGN_EXT,
  input  logic [ADDR_W-1:0]           BASE_ADDR,
  input  logic [COORD_W-1:0]          IMG_W,
  input  logic [COORD_W-1:0]          IMG_H,
  output logic [ADDR_W-1:0]           MEM_ADDR,
  output logic                        MEM_RE,
  input  logic [DATA_W-1:0]           ReadMem,
  output logic                        BUSY,
  output logic                        HANDSHAKE,
  output logic [DATA_W*MAX_BURST-1:0] READ
);

  localparam int RC_W = COORD_W + 1;
  localparam int RD_W = DATA_W * MAX_BURST;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               vertical;
    logic [LEN_W-1:0]   len;
    logic               sign_ext;
    logic [ADDR_W-1:0]  base;
    logic [COORD_W-1:0] img_w;
    logic [COORD_W-1:0] img_h;
  } req_t;

  typedef struct packed {
    logic             valid;
    logic             pad;
    logic [LEN_W-1:0] slot;
  } tag_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d, req_in, src;
  logic [LEN_W-1:0]  idx_q, idx_d, issue_k, len_eff;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, lin_addr;
  logic              mem_re_q, mem_re_d;
  logic [RD_W-1:0]   read_q, read_d;
  tag_t              pipe_q [MEM_LAT+1];
  tag_t              pipe_d [MEM_LAT+1];
  tag_t              exit_tag;
  logic [RC_W-1:0]   k_ext, r, c;
  logic              in_bounds, issue, last_cap;

  always_comb begin
    if (LEN == '0)                        len_eff = LEN_W'(1);
    else if (LEN > LEN_W'(MAX_BURST))     len_eff = LEN_W'(MAX_BURST);
    else                                  len_eff = LEN;
    req_in = '{row: ROW, col: COL, vertical: VERTICAL, len: len_eff, sign_ext: SIGN_EXT,
               base: BASE_ADDR, img_w: IMG_W, img_h: IMG_H};
  end

  // Element 0 is generated from the live inputs in the accept cycle so that the
  // registered address appears on the bus one cycle after START.
  always_comb begin
    src     = req_q;
    issue_k = idx_q + LEN_W'(1);
    if (state_q == IDLE) begin
      src     = req_in;
      issue_k = '0;
    end
    k_ext     = RC_W'(issue_k);
    r         = RC_W'(src.row) + (src.vertical ? k_ext : '0);
    c         = RC_W'(src.col) + (src.vertical ? '0 : k_ext);
    in_bounds = (r < RC_W'(src.img_h)) && (c < RC_W'(src.img_w));
    lin_addr  = src.base + ADDR_W'(r) * ADDR_W'(src.img_w) + ADDR_W'(c);
  end

  assign exit_tag = pipe_q[MEM_LAT];
  assign last_cap = (state_q == DRAIN) && exit_tag.valid &&
                    (exit_tag.slot == req_q.len - LEN_W'(1));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    idx_d      = idx_q;
    mem_addr_d = mem_addr_q;
    mem_re_d   = 1'b0;
    read_d     = read_q;
    issue      = 1'b0;
    pipe_d[0]  = '0;
    for (int i = 1; i <= MEM_LAT; i++) pipe_d[i] = pipe_q[i-1];

    unique case (state_q)
      IDLE: begin
        if (START) begin
          req_d   = req_in;
          idx_d   = '0;
          read_d  = '0;
          issue   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_k < req_q.len) begin
          idx_d = issue_k;
          issue = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN:   if (last_cap) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      pipe_d[0] = '{valid: 1'b1, pad: !in_bounds, slot: issue_k};
      if (in_bounds) begin
        mem_re_d   = 1'b1;
        mem_addr_d = lin_addr;
      end
    end

    if (exit_tag.valid)
      read_d[int'(exit_tag.slot)*DATA_W +: DATA_W] = exit_tag.pad ? '0 : ReadMem;

    if (last_cap && req_q.sign_ext && (req_q.len == LEN_W'(1)))
      read_d = {{(RD_W-DATA_W){read_d[DATA_W-1]}}, read_d[DATA_W-1:0]};
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      req_q      <= '0;
      idx_q      <= '0;
      mem_addr_q <= '0;
      mem_re_q   <= 1'b0;
      read_q     <= '0;
      // NOTE: the tag pipe is reset too; a stale valid bit would write READ after an abort.
      for (int i = 0; i <= MEM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      idx_q      <= idx_d;
      mem_addr_q <= mem_addr_d;
      mem_re_q   <= mem_re_d;
      read_q     <= read_d;
      for (int i = 0; i <= MEM_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign MEM_ADDR  = mem_addr_q;
  assign MEM_RE    = mem_re_q;
  assign BUSY      = (state_q == ISSUE) || (state_q == DRAIN);
  assign HANDSHAKE = (state_q == DONE);
  assign READ      = read_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader: two instances (read latency 1 and 2) share one
// memory image; expected bursts are queued at stimulus time and popped at HANDSHAKE.
module tb_mem_burst_reader;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = 32;
  localparam int MB = 4;
  localparam int LW = 3;
  localparam int RW = DW * MB;

  typedef struct {
    logic [RW-1:0] read;
    int            hs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, vert, sext;
  logic [CW-1:0] row, col, img_w, img_h;
  logic [LW-1:0] len;
  logic [AW-1:0] base;
  bit            sel;

  logic          start1, start2;
  logic [AW-1:0] mem_addr1, mem_addr2;
  logic          mem_re1, mem_re2, busy1, busy2, hs1, hs2;
  logic [RW-1:0] read1, read2;
  logic [DW-1:0] rd1, rd2, p2;

  logic [AW-1:0] mem_addr_s;
  logic          mem_re_s, busy_s, hs_s;
  logic [RW-1:0] read_s;

  logic [DW-1:0] mem [0:1023];
  logic [AW-1:0] hold [2];
  exp_t          sb [$];
  int            checks = 0;
  int            errors = 0;

  assign start1     = start & ~sel;
  assign start2     = start & sel;
  assign mem_addr_s = sel ? mem_addr2 : mem_addr1;
  assign mem_re_s   = sel ? mem_re2 : mem_re1;
  assign busy_s     = sel ? busy2 : busy1;
  assign hs_s       = sel ? hs2 : hs1;
  assign read_s     = sel ? read2 : read1;

  mem_burst_reader #(.MEM_LAT(1)) u_lat1 (
    .CLK(clk), .RESET(rst), .START(start1), .ROW(row), .COL(col), .VERTICAL(vert),
    .LEN(len), .SIGN_EXT(sext), .BASE_ADDR(base), .IMG_W(img_w), .IMG_H(img_h),
    .MEM_ADDR(mem_addr1), .MEM_RE(mem_re1), .ReadMem(rd1), .BUSY(busy1),
    .HANDSHAKE(hs1), .READ(read1)
  );

  mem_burst_reader #(.MEM_LAT(2)) u_lat2 (
    .CLK(clk), .RESET(rst), .START(start2), .ROW(row), .COL(col), .VERTICAL(vert),
    .LEN(len), .SIGN_EXT(sext), .BASE_ADDR(base), .IMG_W(img_w), .IMG_H(img_h),
    .MEM_ADDR(mem_addr2), .MEM_RE(mem_re2), .ReadMem(rd2), .BUSY(busy2),
    .HANDSHAKE(hs2), .READ(read2)
  );

  initial begin
    rd1 = '0;
    rd2 = '0;
    p2  = '0;
  end

  always @(posedge clk) if (mem_re1) rd1 <= mem[mem_addr1[9:0]];

  always @(posedge clk) begin
    p2  <= mem_re2 ? mem[mem_addr2[9:0]] : '0;
    rd2 <= p2;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic run_req(input bit s, input int r0, input int c0, input bit v, input int l,
                         input bit se, input int b, input int w, input int h, input bit poke);
    int            lat, el, hs_at, rr, cc;
    bit            inb [MB];
    logic [AW-1:0] ea [MB];
    logic [RW-1:0] er;
    exp_t          e;
    lat = s ? 2 : 1;
    el  = (l == 0) ? 1 : ((l > MB) ? MB : l);
    er  = '0;
    for (int k = 0; k < el; k++) begin
      rr     = v ? r0 + k : r0;
      cc     = v ? c0 : c0 + k;
      inb[k] = (rr < h) && (cc < w);
      ea[k]  = AW'(b + rr * w + cc);
      if (inb[k]) er[k*DW +: DW] = mem[ea[k][9:0]];
    end
    if (el == 1 && se) er = {{(RW-DW){er[DW-1]}}, er[DW-1:0]};
    e.read = er;
    e.hs   = el + lat + 1;
    sb.push_back(e);

    @(negedge clk);
    sel   = s;
    row   = CW'(r0);
    col   = CW'(c0);
    vert  = v;
    len   = LW'(l);
    sext  = se;
    base  = AW'(b);
    img_w = CW'(w);
    img_h = CW'(h);
    start = 1'b1;
    hs_at = -1;
    for (int n = 1; n <= 40 && hs_at < 0; n++) begin
      @(negedge clk);
      start = (poke && n == 2);
      if (n == 1) begin
        check("busy_after_accept", 64'(busy_s), 64'd1);
        check("read_cleared", read_s, 64'd0);
      end
      if (n <= el) begin
        check("mem_re", 64'(mem_re_s), 64'(inb[n-1]));
        if (inb[n-1]) hold[s] = ea[n-1];
        check("mem_addr", 64'(mem_addr_s), 64'(hold[s]));
      end
      if (n == el + 1) check("mem_re_after_burst", 64'(mem_re_s), 64'd0);
      if (hs_s) hs_at = n;
    end
    e = sb.pop_front();
    check("handshake_cycle", 64'(hs_at), 64'(e.hs));
    if (hs_at > 0) begin
      check("read_result", read_s, e.read);
      check("busy_in_done", 64'(busy_s), 64'd0);
    end
    start = poke;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 2) begin
        check("idle_busy", 64'(busy_s), 64'd0);
        check("idle_handshake", 64'(hs_s), 64'd0);
        check("read_hold", read_s, e.read);
      end
    end
  endtask

  initial begin
    int hs_seen;
    rst = 1'b1; start = 1'b0; sel = 1'b0; vert = 1'b0; sext = 1'b0;
    row = '0; col = '0; len = '0; base = '0; img_w = '0; img_h = '0;
    hold[0] = '0;
    hold[1] = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 37 + 16'h1234);
    mem[16'h113] = 16'h8001;
    mem[4] = 16'h000A; mem[5] = 16'h000B; mem[6] = 16'h000C;
    mem[1] = 16'h1111; mem[9] = 16'h3333; mem[13] = 16'h4444;
    mem[7] = 16'hF00D;
    mem[16'h300] = 16'h9000; mem[16'h301] = 16'h8888;

    repeat (2) @(negedge clk);
    check("rst_addr1", 64'(mem_addr1), 64'd0);
    check("rst_re1", 64'(mem_re1), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_hs1", 64'(hs1), 64'd0);
    check("rst_read1", read1, 64'd0);
    check("rst_addr2", 64'(mem_addr2), 64'd0);
    check("rst_re2", 64'(mem_re2), 64'd0);
    check("rst_busy2", 64'(busy2), 64'd0);
    check("rst_hs2", 64'(hs2), 64'd0);
    check("rst_read2", read2, 64'd0);
    rst = 1'b0;

    run_req(0, 2, 3, 0, 1, 1, 'h100, 8, 8, 0);   // scalar, sign-extended
    check("scalar_literal", read1, 64'hFFFF_FFFF_FFFF_8001);
    run_req(0, 1, 0, 0, 3, 0, 0, 4, 4, 0);       // horizontal burst
    check("horiz_literal", read1, 64'h0000_000C_000B_000A);
    run_req(1, 0, 1, 1, 4, 0, 0, 4, 4, 0);       // vertical burst, latency 2
    run_req(0, 0, 2, 0, 4, 0, 0, 4, 4, 0);       // right-edge padding
    run_req(0, 1, 1, 0, 2, 0, 'h40, 8, 8, 1);    // START while busy and in DONE
    run_req(1, 3, 3, 0, 0, 0, 'h20, 8, 8, 0);    // LEN=0 acts as 1
    run_req(0, 0, 7, 0, 0, 1, 0, 8, 8, 0);       // LEN=0 with sign extension
    run_req(0, 0, 0, 0, 7, 0, 'h200, 8, 8, 0);   // LEN=7 clamps to 4
    run_req(1, 0, 0, 0, 2, 1, 'h300, 8, 8, 0);   // SIGN_EXT ignored for bursts
    run_req(0, 0, 0, 0, 3, 0, 0, 0, 8, 0);       // IMG_W=0
    run_req(1, 0, 0, 1, 2, 0, 0, 8, 0, 0);       // IMG_H=0
    run_req(1, 2, 0, 1, 4, 0, 0, 4, 3, 0);       // bottom-edge padding

    @(negedge clk);
    sel = 1'b0; row = '0; col = '0; vert = 1'b0; len = 3'd4; sext = 1'b0;
    base = '0; img_w = 16'd4; img_h = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold[0] = '0;
    hold[1] = '0;
    check("abort_busy", 64'(busy1), 64'd0);
    check("abort_re", 64'(mem_re1), 64'd0);
    check("abort_addr", 64'(mem_addr1), 64'd0);
    check("abort_read", read1, 64'd0);
    hs_seen = 0;
    for (int n = 0; n < 8; n++) begin
      if (hs1) hs_seen++;
      @(negedge clk);
    end
    check("abort_no_handshake", 64'(hs_seen), 64'd0);
    run_req(0, 1, 0, 0, 4, 0, 0, 4, 4, 0);       // accepted normally after abort

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
